// File: rtl/lif_neuron_array.sv
// Array of leaky integrate-and-fire neurons advanced in lock-step, one
// timestep per valid input beat, with refractory period, saturating
// potentials and a saturating spike counter.
module lif_neuron_array #(
  parameter int unsigned N_NEURONS     = 4,
  parameter int unsigned IN_W          = 8,
  parameter int unsigned POT_W         = 12,
  parameter int unsigned LEAK_SHIFT    = 3,
  parameter int unsigned REFRAC_CYCLES = 2,
  parameter int unsigned CNT_W         = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  input  logic [N_NEURONS*IN_W-1:0]    input_current,
  input  logic [POT_W-1:0]             threshold,
  input  logic                         reset_mode,
  output logic [N_NEURONS-1:0]         spike,
  output logic                         spike_valid,
  output logic [N_NEURONS*POT_W-1:0]   membrane_potential,
  output logic [CNT_W-1:0]             spike_count
);

  localparam int unsigned RW = (REFRAC_CYCLES > 0) ? $clog2(REFRAC_CYCLES + 1) : 1;
  localparam int unsigned PW = $clog2(N_NEURONS + 1);
  localparam int unsigned SW = ((CNT_W > PW) ? CNT_W : PW) + 1;
  localparam int unsigned XW = POT_W + 1;
  localparam logic [XW-1:0]    POT_MAX  = {1'b0, {POT_W{1'b1}}};
  localparam logic [SW-1:0]    CNT_MAX  = SW'({CNT_W{1'b1}});
  localparam logic [RW-1:0]    REFRAC_V = RW'(REFRAC_CYCLES);

  logic [POT_W-1:0]     pot_q    [N_NEURONS];
  logic [POT_W-1:0]     pot_d    [N_NEURONS];
  logic [RW-1:0]        refrac_q [N_NEURONS];
  logic [RW-1:0]        refrac_d [N_NEURONS];
  logic [N_NEURONS-1:0] spike_q, spike_d;
  logic                 valid_q, valid_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic [XW-1:0]        v_ext    [N_NEURONS];
  logic [XW-1:0]        v_leak   [N_NEURONS];
  logic [XW-1:0]        v_sum    [N_NEURONS];
  logic [POT_W-1:0]     v_sat    [N_NEURONS];
  logic [PW-1:0]        pop;
  logic [SW-1:0]        cnt_sum;

  // Next-state for every neuron plus the spike counter.
  always_comb begin
    spike_d = '0;
    valid_d = in_valid;
    cnt_d   = cnt_q;
    pop     = '0;
    cnt_sum = '0;
    for (int i = 0; i < N_NEURONS; i++) begin
      pot_d[i]    = pot_q[i];
      refrac_d[i] = refrac_q[i];
      v_ext[i]    = {1'b0, pot_q[i]};
      // A zero shift means "no leak", not "leak everything".
      v_leak[i]   = (LEAK_SHIFT == 0) ? '0 : (v_ext[i] >> LEAK_SHIFT);
      v_sum[i]    = v_ext[i] - v_leak[i] + XW'(input_current[i*IN_W +: IN_W]);
      v_sat[i]    = (v_sum[i] > POT_MAX) ? POT_MAX[POT_W-1:0] : v_sum[i][POT_W-1:0];
      if (in_valid) begin
        if (refrac_q[i] != '0) begin
          refrac_d[i] = refrac_q[i] - RW'(1);
        end else if (v_sat[i] >= threshold) begin
          spike_d[i]  = 1'b1;
          pot_d[i]    = reset_mode ? (v_sat[i] - threshold) : '0;
          refrac_d[i] = REFRAC_V;
        end else begin
          pot_d[i]    = v_sat[i];
        end
      end
      pop = pop + PW'(spike_d[i]);
    end
    if (in_valid) begin
      cnt_sum = SW'(cnt_q) + SW'(pop);
      cnt_d   = (cnt_sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : cnt_sum[CNT_W-1:0];
    end
  end

  // State register; reset wins over a concurrent valid beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_NEURONS; i++) begin
        pot_q[i]    <= '0;
        refrac_q[i] <= '0;
      end
      spike_q <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      for (int i = 0; i < N_NEURONS; i++) begin
        pot_q[i]    <= pot_d[i];
        refrac_q[i] <= refrac_d[i];
      end
      spike_q <= spike_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  // Pack registered potentials onto the output bus.
  always_comb begin
    membrane_potential = '0;
    for (int i = 0; i < N_NEURONS; i++) begin
      membrane_potential[i*POT_W +: POT_W] = pot_q[i];
    end
  end

  assign spike       = spike_q;
  assign spike_valid = valid_q;
  assign spike_count = cnt_q;

endmodule

// File: tb/tb_lif_neuron_array.sv
// Self-checking bench: two builds (leak shift 3 and leak disabled) driven by
// the same inputs, compared every cycle against an arithmetic reference model.
module tb_lif_neuron_array;

  localparam int N  = 4;
  localparam int PM = 4095;
  localparam int CM = 65535;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] input_current;
  logic [11:0] threshold;
  logic        reset_mode;

  logic [3:0]  spk  [2];
  logic        vld  [2];
  logic [47:0] pot  [2];
  logic [15:0] cnt  [2];

  int checks   = 0;
  int failures = 0;

  // Reference state: [build][neuron]
  int  mv   [2][N];
  int  mr   [2][N];
  int  mcnt [2];
  bit  mspk [2][N];
  bit  mvld;

  always #5 clk = ~clk;

  lif_neuron_array #(.LEAK_SHIFT(3)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .input_current(input_current),
    .threshold(threshold), .reset_mode(reset_mode), .spike(spk[0]),
    .spike_valid(vld[0]), .membrane_potential(pot[0]), .spike_count(cnt[0]));

  lif_neuron_array #(.LEAK_SHIFT(0)) dut_noleak (
    .clk(clk), .reset(reset), .in_valid(in_valid), .input_current(input_current),
    .threshold(threshold), .reset_mode(reset_mode), .spike(spk[1]),
    .spike_valid(vld[1]), .membrane_potential(pot[1]), .spike_count(cnt[1]));

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int pot_of(input int b, input int i);
    return int'(pot[b][i*12 +: 12]);
  endfunction

  task automatic model_clear();
    for (int b = 0; b < 2; b++) begin
      mcnt[b] = 0;
      for (int i = 0; i < N; i++) begin
        mv[b][i] = 0; mr[b][i] = 0; mspk[b][i] = 0;
      end
    end
    mvld = 0;
  endtask

  task automatic model_step(input bit v, input logic [31:0] cur, input int thr, input bit mode);
    mvld = v;
    for (int b = 0; b < 2; b++) begin
      int ls;
      int fired;
      ls = (b == 0) ? 3 : 0;
      fired = 0;
      for (int i = 0; i < N; i++) begin
        mspk[b][i] = 0;
        if (v) begin
          if (mr[b][i] > 0) begin
            mr[b][i] = mr[b][i] - 1;
          end else begin
            int nv;
            nv = mv[b][i] - ((ls == 0) ? 0 : (mv[b][i] / (1 << ls))) + int'(cur[i*8 +: 8]);
            if (nv > PM) nv = PM;
            if (nv >= thr) begin
              mspk[b][i] = 1;
              fired++;
              mv[b][i] = mode ? nv - thr : 0;
              mr[b][i] = 2;
            end else begin
              mv[b][i] = nv;
            end
          end
        end
      end
      mcnt[b] = mcnt[b] + fired;
      if (mcnt[b] > CM) mcnt[b] = CM;
    end
  endtask

  task automatic check_all();
    for (int b = 0; b < 2; b++) begin
      chk($sformatf("valid[%0d]", b), int'(vld[b]), int'(mvld));
      chk($sformatf("count[%0d]", b), int'(cnt[b]), mcnt[b]);
      for (int i = 0; i < N; i++) begin
        chk($sformatf("spike[%0d][%0d]", b, i), int'(spk[b][i]), int'(mspk[b][i]));
        chk($sformatf("pot[%0d][%0d]", b, i), pot_of(b, i), mv[b][i]);
      end
    end
  endtask

  task automatic step(input bit v, input logic [31:0] cur, input int thr, input bit mode);
    @(negedge clk);
    reset = 1'b0; in_valid = v; input_current = cur;
    threshold = 12'(thr); reset_mode = mode;
    @(posedge clk);
    #1;
    model_step(v, cur, thr, mode);
    check_all();
  endtask

  task automatic do_reset(input bit v);
    @(negedge clk);
    reset = 1'b1; in_valid = v; input_current = 32'h3232_3232;
    threshold = 12'd100; reset_mode = 1'b0;
    @(posedge clk);
    #1;
    model_clear();
    check_all();
  endtask

  int e1 [8];
  int e3 [7];

  initial begin
    reset = 1'b1; in_valid = 1'b0; input_current = '0;
    threshold = '0; reset_mode = 1'b0;

    // Reset state
    do_reset(1'b0);
    chk("rst_pot0", pot_of(0, 0), 0);

    // Scenario 1: mode 0, threshold 100, neuron0 input 50
    e1 = '{50, 94, 0, 0, 0, 50, 94, 0};
    for (int s = 0; s < 8; s++) begin
      step(1'b1, 32'd50, 100, 1'b0);
      chk($sformatf("s1_v0_step%0d", s + 1), pot_of(0, 0), e1[s]);
      chk($sformatf("s1_spk_step%0d", s + 1), int'(spk[0][0]), (s == 2 || s == 7) ? 1 : 0);
      chk($sformatf("s1_v1_step%0d", s + 1), pot_of(0, 1), 0);
    end
    chk("s1_count", int'(cnt[0]), 2);

    // Scenario 2: input 10 for 50 steps converges without firing
    do_reset(1'b1);
    for (int s = 0; s < 50; s++) step(1'b1, 32'd10, 100, 1'b0);
    chk("s2_count", int'(cnt[0]), 0);
    chk("s2_bound", (pot_of(0, 0) <= 87) ? 1 : 0, 1);

    // Scenario 3: reset-by-subtraction
    do_reset(1'b0);
    e3 = '{50, 94, 33, 33, 33, 79, 20};
    for (int s = 0; s < 7; s++) begin
      step(1'b1, 32'd50, 100, 1'b1);
      chk($sformatf("s3_v0_step%0d", s + 1), pot_of(0, 0), e3[s]);
    end

    // Scenario 4: gaps between valid beats freeze state
    do_reset(1'b0);
    for (int s = 0; s < 16; s++) begin
      step((s % 4 == 0) || (s % 4 == 3), 32'd50, 100, 1'b0);
    end

    // Scenario 5: no-leak build saturates at the top of range
    do_reset(1'b0);
    for (int s = 0; s < 16; s++) step(1'b1, 32'd255, 4095, 1'b0);
    chk("s5_v_4080", pot_of(1, 0), 4080);
    step(1'b1, 32'd255, 4095, 1'b0);
    chk("s5_sat_spike", int'(spk[1][0]), 1);
    chk("s5_sat_v0", pot_of(1, 0), 0);

    // Scenario 6: reset while refractory, then integrate immediately
    do_reset(1'b0);
    for (int s = 0; s < 4; s++) step(1'b1, 32'd50, 100, 1'b0);
    do_reset(1'b1);
    chk("s6_cnt0", int'(cnt[0]), 0);
    chk("s6_vld0", int'(vld[0]), 0);
    step(1'b1, 32'd50, 100, 1'b0);
    chk("s6_v_50", pot_of(0, 0), 50);

    // Threshold zero: every active neuron fires
    do_reset(1'b0);
    step(1'b1, 32'h0102_0300, 0, 1'b0);
    chk("thr0_spikes", int'(spk[0]), 15);

    // Randomised traffic with occasional resets
    do_reset(1'b0);
    for (int s = 0; s < 400; s++) begin
      if ($urandom_range(0, 49) == 0) begin
        do_reset(1'($urandom_range(0, 1)));
      end else begin
        int thr;
        thr = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(0, 600));
        step(($urandom_range(0, 9) < 7), $urandom, thr, 1'($urandom_range(0, 1)));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
